// File: rtl/sbox_arbiter.sv
// Two-requester round-robin front end for a shared registered 32-bit AES S-Box, with requester-0 burst lock.
// Define SBOX_ARB_STATS_EN to add the grant/stall counters and their stats_clr input.
module sbox_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_lock,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic [WIDTH-1:0] sbox_in,
    input  logic [WIDTH-1:0] sbox_out,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
`ifdef SBOX_ARB_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [15:0]      grant0_cnt,
    output logic [15:0]      grant1_cnt,
    output logic [15:0]      stall1_cnt
`endif
);

    logic               r_last;
    logic               r_locked;
    logic [LATENCY-1:0] r_tag_vld;
    logic [LATENCY-1:0] r_tag_id;

    logic               w_contend;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_gnt_any;
    logic               w_gnt_id;

    // Grants are suppressed while reset is held so ready never pulses during reset.
    always_comb begin
        w_contend = req0_valid && req1_valid;
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        if (rst_n) begin
            if (w_contend) begin
                if (r_locked || r_last) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign w_gnt_any  = w_gnt0 || w_gnt1;
    assign w_gnt_id   = w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_comb begin
        sbox_in = '0;
        if (w_gnt0) begin
            sbox_in = req0_data;
        end else if (w_gnt1) begin
            sbox_in = req1_data;
        end
    end

    // r_last holds the winner of the most recent unlocked contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_locked <= 1'b0;
        end else begin
            if (w_contend && !r_locked) begin
                r_last <= w_gnt1;
            end
            if (!req0_valid) begin
                r_locked <= 1'b0;
            end else if (w_gnt0) begin
                r_locked <= req0_lock;
            end
        end
    end

    // Tag pipeline mirrors the S-Box latency; stage 0 captures this cycle's grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld[0] <= 1'b0;
            r_tag_id[0]  <= 1'b0;
        end else begin
            r_tag_vld[0] <= w_gnt_any;
            r_tag_id[0]  <= w_gnt_id;
        end
    end

    for (genvar g = 1; g < LATENCY; g++) begin : g_tag_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_tag_vld[g] <= 1'b0;
                r_tag_id[g]  <= 1'b0;
            end else begin
                r_tag_vld[g] <= r_tag_vld[g-1];
                r_tag_id[g]  <= r_tag_id[g-1];
            end
        end
    end

    assign rsp0_valid = r_tag_vld[LATENCY-1] && !r_tag_id[LATENCY-1];
    assign rsp1_valid = r_tag_vld[LATENCY-1] &&  r_tag_id[LATENCY-1];
    assign rsp_data   = sbox_out;
    assign busy       = |r_tag_vld;

`ifdef SBOX_ARB_STATS_EN
    logic [15:0] r_grant0_cnt;
    logic [15:0] r_grant1_cnt;
    logic [15:0] r_stall1_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant0_cnt <= '0;
            r_grant1_cnt <= '0;
            r_stall1_cnt <= '0;
        end else if (stats_clr) begin
            r_grant0_cnt <= '0;
            r_grant1_cnt <= '0;
            r_stall1_cnt <= '0;
        end else begin
            if (w_gnt0) begin
                r_grant0_cnt <= sat_inc(r_grant0_cnt);
            end
            if (w_gnt1) begin
                r_grant1_cnt <= sat_inc(r_grant1_cnt);
            end
            if (req1_valid && !w_gnt1) begin
                r_stall1_cnt <= sat_inc(r_stall1_cnt);
            end
        end
    end

    assign grant0_cnt = r_grant0_cnt;
    assign grant1_cnt = r_grant1_cnt;
    assign stall1_cnt = r_stall1_cnt;
`endif

endmodule

// File: tb/tb_sbox_arbiter.sv
// Directed bench for sbox_arbiter: a LATENCY=1 and a LATENCY=3 instance, each fed by a behavioural AES S-Box.
module tb_sbox_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Behavioural AES S-Box: GF(2^8) inverse by search, then the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox8(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sbox32(input logic [31:0] w);
        return {sbox8(w[31:24]), sbox8(w[23:16]), sbox8(w[15:8]), sbox8(w[7:0])};
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instance A: LATENCY = 1
    logic        a_rst_n, a_req0_valid, a_req0_lock, a_req0_ready, a_req1_valid, a_req1_ready;
    logic        a_rsp0_valid, a_rsp1_valid, a_busy;
    logic [31:0] a_req0_data, a_req1_data, a_sbox_in, a_sbox_out, a_rsp_data;
    // Instance B: LATENCY = 3
    logic        b_rst_n, b_req0_valid, b_req0_lock, b_req0_ready, b_req1_valid, b_req1_ready;
    logic        b_rsp0_valid, b_rsp1_valid, b_busy;
    logic [31:0] b_req0_data, b_req1_data, b_sbox_in, b_sbox_out, b_rsp_data;
    logic [31:0] b_s1, b_s2;
`ifdef SBOX_ARB_STATS_EN
    logic        a_stats_clr, b_stats_clr;
    logic [15:0] a_g0, a_g1, a_st1, b_g0, b_g1, b_st1;
`endif

    always @(posedge clk) a_sbox_out <= sbox32(a_sbox_in);
    always @(posedge clk) begin
        b_s1       <= sbox32(b_sbox_in);
        b_s2       <= b_s1;
        b_sbox_out <= b_s2;
    end

    sbox_arbiter #(.WIDTH(32), .LATENCY(1)) u_a (
        .clk(clk), .rst_n(a_rst_n),
        .req0_valid(a_req0_valid), .req0_data(a_req0_data), .req0_lock(a_req0_lock), .req0_ready(a_req0_ready),
        .req1_valid(a_req1_valid), .req1_data(a_req1_data), .req1_ready(a_req1_ready),
        .sbox_in(a_sbox_in), .sbox_out(a_sbox_out),
        .rsp0_valid(a_rsp0_valid), .rsp1_valid(a_rsp1_valid), .rsp_data(a_rsp_data), .busy(a_busy)
`ifdef SBOX_ARB_STATS_EN
        , .stats_clr(a_stats_clr), .grant0_cnt(a_g0), .grant1_cnt(a_g1), .stall1_cnt(a_st1)
`endif
    );

    sbox_arbiter #(.WIDTH(32), .LATENCY(3)) u_b (
        .clk(clk), .rst_n(b_rst_n),
        .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_lock(b_req0_lock), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
        .sbox_in(b_sbox_in), .sbox_out(b_sbox_out),
        .rsp0_valid(b_rsp0_valid), .rsp1_valid(b_rsp1_valid), .rsp_data(b_rsp_data), .busy(b_busy)
`ifdef SBOX_ARB_STATS_EN
        , .stats_clr(b_stats_clr), .grant0_cnt(b_g0), .grant1_cnt(b_g1), .stall1_cnt(b_st1)
`endif
    );

    initial begin
        a_rst_n = 1'b0; a_req0_valid = 1'b0; a_req0_lock = 1'b0; a_req1_valid = 1'b0;
        a_req0_data = '0; a_req1_data = '0;
        b_rst_n = 1'b0; b_req0_valid = 1'b0; b_req0_lock = 1'b0; b_req1_valid = 1'b0;
        b_req0_data = '0; b_req1_data = '0;
`ifdef SBOX_ARB_STATS_EN
        a_stats_clr = 1'b0; b_stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        // Reset held: valids present but nothing may be granted
        a_req0_valid = 1'b1; a_req1_valid = 1'b1;
        #1;
        chk1("rst_ready0", a_req0_ready, 1'b0);
        chk1("rst_ready1", a_req1_ready, 1'b0);
        chk1("rst_rsp0", a_rsp0_valid, 1'b0);
        chk1("rst_rsp1", a_rsp1_valid, 1'b0);
        chk1("rst_busy", a_busy, 1'b0);
        chk32("rst_sbox_in", a_sbox_in, 32'h0);
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;
        @(negedge clk);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(posedge clk); #1;

        // Requester 0 alone
        a_req0_valid = 1'b1; a_req0_data = 32'h00000000;
        #1;
        chk1("t1_ready0", a_req0_ready, 1'b1);
        chk1("t1_ready1", a_req1_ready, 1'b0);
        @(posedge clk); #1;
        a_req0_valid = 1'b0;
        chk1("t1_rsp0", a_rsp0_valid, 1'b1);
        chk32("t1_data", a_rsp_data, 32'h63636363);
        chk1("t1_rsp1", a_rsp1_valid, 1'b0);
        chk1("t1_busy", a_busy, 1'b1);
        @(posedge clk); #1;
        chk1("t1_rsp0_off", a_rsp0_valid, 1'b0);
        chk1("t1_idle", a_busy, 1'b0);

        // Requester 1 alone
        a_req1_valid = 1'b1; a_req1_data = 32'h01020304;
        #1;
        chk1("t2_ready1", a_req1_ready, 1'b1);
        chk32("t2_sbox_in", a_sbox_in, 32'h01020304);
        @(posedge clk); #1;
        a_req1_valid = 1'b0;
        chk1("t2_rsp1", a_rsp1_valid, 1'b1);
        chk32("t2_data", a_rsp_data, 32'h7c777bf2);
        chk1("t2_rsp0", a_rsp0_valid, 1'b0);
        @(posedge clk); #1;

        // Contention without lock: strict alternation starting with requester 0
        a_req0_valid = 1'b1; a_req0_data = 32'h53535353;
        a_req1_valid = 1'b1; a_req1_data = 32'h00000000;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("t3_gnt0", a_req0_ready, (i % 2) == 0);
            chk1("t3_gnt1", a_req1_ready, (i % 2) == 1);
            chk32("t3_sbox_in", a_sbox_in, ((i % 2) == 0) ? 32'h53535353 : 32'h00000000);
            @(posedge clk); #1;
            chk1("t3_rsp0", a_rsp0_valid, (i % 2) == 0);
            chk1("t3_rsp1", a_rsp1_valid, (i % 2) == 1);
            chk32("t3_data", a_rsp_data, ((i % 2) == 0) ? 32'hedededed : 32'h63636363);
        end
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;
        @(posedge clk); #1;

`ifdef SBOX_ARB_STATS_EN
        chk32("st_g0", 32'(a_g0), 32'd3);
        chk32("st_g1", 32'(a_g1), 32'd3);
        chk32("st_stall1", 32'(a_st1), 32'd2);
        // Clear coincides with a grant: clear must win
        a_stats_clr = 1'b1; a_req0_valid = 1'b1;
        @(posedge clk); #1;
        a_stats_clr = 1'b0; a_req0_valid = 1'b0;
        chk32("st_clr_g0", 32'(a_g0), 32'd0);
        chk32("st_clr_stall", 32'(a_st1), 32'd0);
        @(posedge clk); #1;
`endif

        // Lock held for three grants, released on the fourth; requester 1 wins the fifth
        a_req0_valid = 1'b1; a_req0_data = 32'h11111111;
        a_req1_valid = 1'b1; a_req1_data = 32'h22222222;
        for (int i = 0; i < 5; i++) begin
            a_req0_lock = (i < 3);
            #1;
            chk1("t4_gnt0", a_req0_ready, i < 4);
            chk1("t4_gnt1", a_req1_ready, i == 4);
            @(posedge clk); #1;
        end
        a_req0_valid = 1'b0; a_req1_valid = 1'b0; a_req0_lock = 1'b0;
`ifdef SBOX_ARB_STATS_EN
        chk32("t4_stall1", 32'(a_st1), 32'd4);
        chk32("t4_g0", 32'(a_g0), 32'd4);
        chk32("t4_g1", 32'(a_g1), 32'd1);
`endif
        @(posedge clk); #1;

        // Lock dropped by req0_valid going low: next contention is plain round-robin
        a_req0_valid = 1'b1; a_req1_valid = 1'b1; a_req0_lock = 1'b1;
        #1;
        chk1("t4b_lockgnt", a_req0_ready, 1'b1);
        @(posedge clk); #1;
        a_req0_valid = 1'b0; a_req0_lock = 1'b0;
        #1;
        chk1("t4b_sole1", a_req1_ready, 1'b1);
        @(posedge clk); #1;
        a_req0_valid = 1'b1;
        #1;
        chk1("t4b_rr_gnt1", a_req1_ready, 1'b1);
        chk1("t4b_rr_gnt0", a_req0_ready, 1'b0);
        @(posedge clk); #1;
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;

        // LATENCY = 3: response exactly three cycles after accept
        b_req0_valid = 1'b1; b_req0_data = 32'hff000000;
        #1;
        chk1("l3_ready0", b_req0_ready, 1'b1);
        @(posedge clk); #1;
        b_req0_valid = 1'b0;
        chk1("l3_c1_busy", b_busy, 1'b1);
        chk1("l3_c1_rsp0", b_rsp0_valid, 1'b0);
        @(posedge clk); #1;
        chk1("l3_c2_busy", b_busy, 1'b1);
        chk1("l3_c2_rsp0", b_rsp0_valid, 1'b0);
        @(posedge clk); #1;
        chk1("l3_c3_rsp0", b_rsp0_valid, 1'b1);
        chk32("l3_c3_data", b_rsp_data, 32'h16636363);
        chk1("l3_c3_busy", b_busy, 1'b1);
        @(posedge clk); #1;
        chk1("l3_c4_rsp0", b_rsp0_valid, 1'b0);
        chk1("l3_c4_busy", b_busy, 1'b0);

        // Reset while two words are in flight drops them and restores last
        b_req0_valid = 1'b1; b_req0_data = 32'haaaaaaaa;
        b_req1_valid = 1'b1; b_req1_data = 32'h55555555;
        #1;
        chk1("rs_gnt0", b_req0_ready, 1'b1);
        @(posedge clk); #1;
        b_req0_valid = 1'b0;
        #1;
        chk1("rs_gnt1", b_req1_ready, 1'b1);
        @(posedge clk); #1;
        b_req1_valid = 1'b0;
        chk1("rs_busy_pre", b_busy, 1'b1);
        b_rst_n = 1'b0;
        #1;
        chk1("rs_busy_now", b_busy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk1("rs_rsp0", b_rsp0_valid, 1'b0);
            chk1("rs_rsp1", b_rsp1_valid, 1'b0);
            chk1("rs_busy", b_busy, 1'b0);
        end
        @(negedge clk);
        b_rst_n = 1'b1;
        @(posedge clk); #1;
        b_req0_valid = 1'b1; b_req1_valid = 1'b1;
        #1;
        chk1("rs_after_gnt0", b_req0_ready, 1'b1);
        chk1("rs_after_gnt1", b_req1_ready, 1'b0);
        @(posedge clk); #1;
        b_req0_valid = 1'b0; b_req1_valid = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sbox_arbiter.md
Name: sbox_arbiter

Overview:
- Shares one registered 32-bit byte-wise S-Box (4 parallel AES S-boxes, fixed pipeline latency) between two requesters.
- Requester 0 is the SNOW 2.0 FSM S1 path. Requester 1 is the auxiliary path: key/IV setup and self-test.
- Does round-robin arbitration with an optional requester-0 burst lock.
- Tags each accepted word in flight and routes the S-Box result back to the requester that issued it.
- Sits directly between the requesters and the S-Box instance.

Parameters:
- WIDTH, 32, data word width. Must equal the S-Box port width.
- LATENCY, 1, S-Box clock-to-output latency in cycles (>=1). Sets the depth of the tag pipeline.

Ports:
- clk  input  1  rising-edge clock, shared with the S-Box.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_lock  input  1  requester 0 asks to hold priority on following cycles.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- sbox_in  output  WIDTH  drives the S-Box input.
- sbox_out  input  WIDTH  S-Box result.
- rsp0_valid  output  1  rsp_data belongs to requester 0.
- rsp1_valid  output  1  rsp_data belongs to requester 1.
- rsp_data  output  WIDTH  sbox_out passed through unmodified.
- busy  output  1  any tag in flight.

Behaviour:
- Arbitration (combinational, same cycle):
  - Handshake is valid && ready. reqN_ready is high only in the cycle that requester is granted. Ready never asserts without valid.
  - At most one grant per cycle.
  - One valid requester: that requester wins.
  - Both valid: the requester that did not win the last contended grant wins (round-robin on `last`).
- Priority state:
  - `last` is a 1-bit register, reset value 1, so requester 0 wins the first contention.
  - `last` updates only on contended grants.
  - Lock register `locked`, reset value 0:
    - Set when requester 0 is granted with req0_lock=1.
    - Cleared when requester 0 is granted with req0_lock=0, or when req0_valid=0.
    - While locked=1, requester 0 wins every contention and `last` does not change.
- sbox_in:
  - Equals the granted requester's data.
  - Equals 0 when there is no grant.
- Tag pipeline: shift register of LATENCY stages, each {valid, id}.
  - Stage 0 loads {grant_any, grant_id} every cycle.
  - rspN_valid is the last stage's valid && id==N.
  - Result: a word accepted at cycle t returns with rspN_valid=1 at cycle t+LATENCY, with rsp_data equal to S-Box(word).
  - Back-to-back accepts give back-to-back responses in issue order.
- No response backpressure: requesters must take a response in the cycle it is valid.
- busy is the OR of all stage valids.
- Reset (async assert, sync deassert by the top level):
  - All tag valids, `locked` and the ready/rsp valids go to 0. `last` goes to 1.
  - In-flight words are dropped; no stale response is ever flagged valid, even though the S-Box data register has no reset.
  - Reset mid-burst discards the lock.
- Boundary cases:
  - A requester deasserting valid in a cycle where it is not granted is legal; nothing is accepted.
  - Same requester granted on consecutive cycles: allowed (sole requester, or locked).
  - Simultaneous lock release and contention: release applies after the grant in that cycle. Requester 0 still wins that cycle; requester 1 wins the next contention.

Optional Feature:
- Macro SBOX_ARB_STATS_EN. When defined, adds outputs:
  - grant0_cnt [15:0] and grant1_cnt [15:0]: count accepted words, saturate at 0xFFFF, reset to 0.
  - stall1_cnt [15:0]: counts cycles with req1_valid=1 and req1_ready=0, saturating, reset to 0.
  - Input stats_clr: synchronous clear of all counters. Clear takes precedence over an increment in the same cycle.
- When not defined: none of these ports or registers exist. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset, then req0 only, data 0x00000000: req0_ready=1 same cycle; rsp0_valid=1 after LATENCY cycles with rsp_data 0x63636363; rsp1_valid stays 0.
- req1 only, data 0x01020304: rsp1_valid after LATENCY cycles with rsp_data 0x7c777bf2.
- Both valid for 4 cycles, lock=0, data 0x53535353 and 0x00000000: grants alternate 0,1,0,1; responses alternate 0xedededed, 0x63636363 in the same order.
- Both valid, req0_lock=1 for 3 grants, then 0: requester 0 granted 4 consecutive cycles (3 locked plus the releasing cycle), then requester 1 granted; stall1_cnt=4 when SBOX_ARB_STATS_EN is defined.
- Assert rst_n=0 one cycle after two accepts: no rspN_valid ever appears for those words; busy=0; the first contention after reset grants requester 0.
- LATENCY=3 build, single req0 word 0xff000000: rsp0_valid exactly 3 cycles later with 0x16636363; busy high for 3 cycles.
